// File: rtl/axi_rd_burst_ctrl.sv
// Single-outstanding AXI4 read burst sequencer: takes one line request, issues AR,
// packs R beats into a line buffer and returns the line with a one-cycle pulse.
module axi_rd_burst_ctrl #(
   parameter int DATA_W = 32,
   parameter int LINE_W = 256,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   // request / response towards the cache read selector
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [7:0]        req_len,
   input  logic [2:0]        req_size,
   input  logic [ID_W-1:0]   req_id,
   output logic              resp_valid,
   output logic [LINE_W-1:0] resp_data,
   output logic [ID_W-1:0]   resp_id,
   output logic              resp_err,
   output logic              busy,
   // AXI4 read address channel
   output logic              arvalid,
   input  logic              arready,
   output logic [31:0]       araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [ID_W-1:0]   arid,
   // AXI4 read data channel
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [ID_W-1:0]   rid,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   // FSM state for checkers: 0 IDLE, 1 ADDR, 2 DATA, 3 DONE, 4 DRAIN
   output logic [2:0]        dbg_state
);

   localparam int NBEAT = LINE_W / DATA_W;
   localparam int CNT_W = $clog2(NBEAT + 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; valid never waits on ready, and ar* payload is held stable while arvalid.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [31:0]         r_addr;
   logic [7:0]          r_len;
   logic [2:0]          r_size;
   logic [ID_W-1:0]     r_id;
   logic [LINE_W-1:0]   r_line;
   logic [CNT_W-1:0]    r_beat_cnt;
   logic                r_err;
   logic                r_flush_pend;

   logic                w_req_ready;
   logic                w_arvalid;
   logic                w_rready;
   logic                w_resp_valid;
   logic                w_accept;
   logic                w_data_beat;
   logic                w_beat_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_req_ready  = 1'b0;
      w_arvalid    = 1'b0;
      w_rready     = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            // flush outranks a simultaneous request
            w_req_ready = ~flush & ~reset;
            if (req_valid && w_req_ready) begin
               w_next = S_ADDR;
            end
         end
         S_ADDR: begin
            // a flush here cannot retract arvalid; the burst is drained instead
            w_arvalid = 1'b1;
            if (arready) begin
               w_next = (flush || r_flush_pend) ? S_DRAIN : S_DATA;
            end
         end
         S_DATA: begin
            w_rready = 1'b1;
            if (rvalid && rlast) begin
               w_next = flush ? S_IDLE : S_DONE;
            end else if (flush) begin
               w_next = S_DRAIN;
            end
         end
         S_DONE: begin
            w_resp_valid = ~flush;
            w_next       = S_IDLE;
         end
         S_DRAIN: begin
            w_rready = 1'b1;
            if (rvalid && rlast) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign w_accept    = req_valid & w_req_ready;
   assign w_data_beat = (r_state == S_DATA) & rvalid;
   assign w_beat_bad  = (rresp != 2'b00) | (rid != r_id);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr       <= '0;
         r_len        <= '0;
         r_size       <= '0;
         r_id         <= '0;
         r_line       <= '0;
         r_beat_cnt   <= '0;
         r_err        <= 1'b0;
         r_flush_pend <= 1'b0;
      end else if (w_accept) begin
         r_addr       <= req_addr;
         r_len        <= req_len;
         r_size       <= req_size;
         r_id         <= req_id;
         r_line       <= '0;
         r_beat_cnt   <= '0;
         r_err        <= 1'b0;
         r_flush_pend <= 1'b0;
      end else begin
         if (r_state == S_ADDR && flush) begin
            r_flush_pend <= 1'b1;
         end
         if (w_data_beat) begin
            // beats past the line capacity still count toward err but are not stored
            for (int i = 0; i < NBEAT; i++) begin
               if (r_beat_cnt == CNT_W'(i)) begin
                  r_line[i*DATA_W +: DATA_W] <= rdata;
               end
            end
            if (r_beat_cnt != CNT_W'(NBEAT)) begin
               r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_beat_bad) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign req_ready  = w_req_ready;
   assign resp_valid = w_resp_valid;
   assign resp_data  = r_line;
   assign resp_id    = r_id;
   assign resp_err   = r_err;
   assign busy       = (r_state != S_IDLE);
   assign arvalid    = w_arvalid;
   assign araddr     = r_addr;
   assign arlen      = r_len;
   assign arsize     = r_size;
   assign arburst    = 2'b01;
   assign arid       = r_id;
   assign rready     = w_rready;
   assign dbg_state  = r_state;

endmodule
